// File: rtl/pll_reset_sequencer.sv
// ---------------------------------------------------------------------------
// pll_reset_sequencer
//
// Brings up the board clocking: pulses the PLL reset, waits for a stable lock,
// then releases the domain resets one at a time (memory, system, video).
// Lock loss at any point after the lock was seen drops every domain back into
// reset. A lock that never arrives retries the PLL reset and counts the
// attempts.
//
// Ports
//   refclk      in   free-running reference clock, the only clock
//   rst         in   synchronous active-high reset
//   locked      in   PLL lock, asynchronous to refclk (synchronized here)
//   soft_rst    in   one-cycle request to replay the staged release
//   pll_rst     out  active-high reset to the PLL
//   rst_mem     out  active-high reset, memory domain
//   rst_sys     out  active-high reset, system/processor domain
//   rst_video   out  active-high reset, video/camera domain
//   ready       out  high only while every domain is out of reset
//   retry_count out  lock-timeout retries since rst, saturates at 15
// ---------------------------------------------------------------------------
module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES      = 8,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int STAGE_GAP_CYCLES    = 16
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked,
  input  logic       soft_rst,
  output logic       pll_rst,
  output logic       rst_mem,
  output logic       rst_sys,
  output logic       rst_video,
  output logic       ready,
  output logic [3:0] retry_count
);

  localparam int SYNC_STAGES = 2;

  // One shared state counter, wide enough for the longest state duration.
  localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                           PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_CD  = (LOCK_STABLE_CYCLES > STAGE_GAP_CYCLES) ?
                           LOCK_STABLE_CYCLES : STAGE_GAP_CYCLES;
  localparam int CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

  // Terminal counts: the state has lasted N cycles when the counter reads N-1.
  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP_CYCLES - 1);

  localparam logic [2:0] ST_PLL_RESET = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] ST_STABLE    = 3'd2;
  localparam logic [2:0] ST_REL_MEM   = 3'd3;
  localparam logic [2:0] ST_REL_SYS   = 3'd4;
  localparam logic [2:0] ST_RUN       = 3'd5;

  // -------------------------------------------------------------------------
  // Lock synchronizer
  // -------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_reg;
  logic [SYNC_STAGES-1:0] sync_next;
  logic                   locked_s;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        assign sync_next[gi] = locked;
      end else begin : g_chain
        assign sync_next[gi] = sync_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge refclk) begin
    if (rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= sync_next;
    end
  end

  assign locked_s = sync_reg[SYNC_STAGES-1];

  // -------------------------------------------------------------------------
  // Sequencer FSM
  // -------------------------------------------------------------------------
  logic [2:0]       state_reg,  state_next;
  logic [CNT_W-1:0] cnt_reg,    cnt_next;
  logic [3:0]       retry_reg,  retry_next;

  always_comb begin
    state_next = state_reg;
    retry_next = retry_reg;
    cnt_next   = cnt_reg + CNT_W'(1);

    case (state_reg)
      ST_PLL_RESET: begin
        if (cnt_reg == PLL_RST_LAST) begin
          state_next = ST_WAIT_LOCK;
        end
      end

      ST_WAIT_LOCK: begin
        if (locked_s) begin
          state_next = ST_STABLE;
        end else if (cnt_reg == TIMEOUT_LAST) begin
          state_next = ST_PLL_RESET;
          if (retry_reg != 4'hF) begin
            retry_next = retry_reg + 4'd1;
          end
        end
      end

      // A dropout before release only restarts the lock wait; the PLL is
      // not reset again because no domain has been released yet.
      ST_STABLE: begin
        if (!locked_s) begin
          state_next = ST_WAIT_LOCK;
        end else if (cnt_reg == STABLE_LAST) begin
          state_next = ST_REL_MEM;
        end
      end

      // Lock loss is tested before soft_rst so it wins when both coincide.
      ST_REL_MEM: begin
        if (!locked_s) begin
          state_next = ST_PLL_RESET;
        end else if (soft_rst) begin
          state_next = ST_STABLE;
        end else if (cnt_reg == GAP_LAST) begin
          state_next = ST_REL_SYS;
        end
      end

      ST_REL_SYS: begin
        if (!locked_s) begin
          state_next = ST_PLL_RESET;
        end else if (soft_rst) begin
          state_next = ST_STABLE;
        end else if (cnt_reg == GAP_LAST) begin
          state_next = ST_RUN;
        end
      end

      ST_RUN: begin
        cnt_next = cnt_reg;  // RUN has no duration; hold so it never wraps
        if (!locked_s) begin
          state_next = ST_PLL_RESET;
        end else if (soft_rst) begin
          state_next = ST_STABLE;
        end
      end

      default: begin
        state_next = ST_PLL_RESET;
      end
    endcase

    // Every state times itself from zero.
    if (state_next != state_reg) begin
      cnt_next = '0;
    end
  end

  // -------------------------------------------------------------------------
  // Output registers: decoded from state_next so the registered outputs
  // always describe the state held in state_reg on the same cycle.
  // -------------------------------------------------------------------------
  logic pll_rst_reg,   pll_rst_next;
  logic rst_mem_reg,   rst_mem_next;
  logic rst_sys_reg,   rst_sys_next;
  logic rst_video_reg, rst_video_next;
  logic ready_reg,     ready_next;

  always_comb begin
    pll_rst_next   = (state_next == ST_PLL_RESET);
    rst_mem_next   = !((state_next == ST_REL_MEM) ||
                       (state_next == ST_REL_SYS) ||
                       (state_next == ST_RUN));
    rst_sys_next   = !((state_next == ST_REL_SYS) ||
                       (state_next == ST_RUN));
    rst_video_next = (state_next != ST_RUN);
    ready_next     = (state_next == ST_RUN);
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_reg     <= ST_PLL_RESET;
      cnt_reg       <= '0;
      retry_reg     <= '0;
      pll_rst_reg   <= 1'b1;
      rst_mem_reg   <= 1'b1;
      rst_sys_reg   <= 1'b1;
      rst_video_reg <= 1'b1;
      ready_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      retry_reg     <= retry_next;
      pll_rst_reg   <= pll_rst_next;
      rst_mem_reg   <= rst_mem_next;
      rst_sys_reg   <= rst_sys_next;
      rst_video_reg <= rst_video_next;
      ready_reg     <= ready_next;
    end
  end

  assign pll_rst     = pll_rst_reg;
  assign rst_mem     = rst_mem_reg;
  assign rst_sys     = rst_sys_reg;
  assign rst_video   = rst_video_reg;
  assign ready       = ready_reg;
  assign retry_count = retry_reg;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pll_reset_sequencer
//
// Directed bench with short parameters (3/100/8/4). Inputs change on the
// falling edge and outputs are sampled on the falling edge, so "after edge k"
// below means the falling edge that follows rising edge k. The output vector
// is {pll_rst, rst_mem, rst_sys, rst_video, ready}.
// ---------------------------------------------------------------------------
module tb_pll_reset_sequencer;

  logic       refclk;
  logic       rst;
  logic       locked;
  logic       soft_rst;
  logic       pll_rst;
  logic       rst_mem;
  logic       rst_sys;
  logic       rst_video;
  logic       ready;
  logic [3:0] retry_count;
  logic [4:0] outs;

  int checks   = 0;
  int failures = 0;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES      (3),
    .LOCK_TIMEOUT_CYCLES (100),
    .LOCK_STABLE_CYCLES  (8),
    .STAGE_GAP_CYCLES    (4)
  ) dut (
    .refclk      (refclk),
    .rst         (rst),
    .locked      (locked),
    .soft_rst    (soft_rst),
    .pll_rst     (pll_rst),
    .rst_mem     (rst_mem),
    .rst_sys     (rst_sys),
    .rst_video   (rst_video),
    .ready       (ready),
    .retry_count (retry_count)
  );

  assign outs = {pll_rst, rst_mem, rst_sys, rst_video, ready};

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s value=%0h", tag, got);
    end
  endtask

  task automatic check_outs(input string tag, input logic [4:0] exp);
    check_val(tag, 32'(outs), 32'(exp));
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge refclk);
  endtask

  // locked has just been raised on this falling edge with the FSM in
  // WAIT_LOCK: seen at edge L+2, mem out at L+10, sys at L+14, video at L+18.
  task automatic release_seq(input string tag);
    step(2);  check_outs({tag, "_wait"},    5'b01110);
    step(8);  check_outs({tag, "_pre_mem"}, 5'b01110);
    step(1);  check_outs({tag, "_mem"},     5'b00110);
    step(3);  check_outs({tag, "_pre_sys"}, 5'b00110);
    step(1);  check_outs({tag, "_sys"},     5'b00010);
    step(3);  check_outs({tag, "_pre_run"}, 5'b00010);
    step(1);  check_outs({tag, "_run"},     5'b00001);
  endtask

  initial begin
    rst      = 1'b1;
    locked   = 1'b0;
    soft_rst = 1'b0;

    // Reset state
    step(3);
    check_outs("reset_outs", 5'b11110);
    check_val("reset_retry", 32'(retry_count), 32'd0);

    // Power-up: pll_rst held 3 cycles after release, lock 10 cycles later
    rst = 1'b0;
    step(1); check_outs("boot_pll1", 5'b11110);
    step(1); check_outs("boot_pll2", 5'b11110);
    step(1); check_outs("boot_wait", 5'b01110);
    step(7);
    locked = 1'b1;
    release_seq("boot");
    check_val("boot_retry", 32'(retry_count), 32'd0);

    // soft_rst in RUN: back to STABLE, PLL untouched; a second pulse while
    // in STABLE is ignored, so release still follows 8+4+4 cycles
    soft_rst = 1'b1;
    step(1); soft_rst = 1'b0;
    check_outs("soft_enter", 5'b01110);
    step(3); soft_rst = 1'b1;
    step(1); soft_rst = 1'b0;
    check_outs("soft_ign", 5'b01110);
    step(3); check_outs("soft_pre_mem", 5'b01110);
    step(1); check_outs("soft_mem", 5'b00110);
    step(4); check_outs("soft_sys", 5'b00010);
    step(4); check_outs("soft_run", 5'b00001);

    // Lock loss in RUN: outputs hold 2 cycles (synchronizer), then PLL reset
    locked = 1'b0;
    step(2); check_outs("loss_sync", 5'b00001);
    step(1); check_outs("loss_pll", 5'b11110);
    check_val("loss_retry", 32'(retry_count), 32'd0);
    step(2); check_outs("loss_pll3", 5'b11110);
    step(1); check_outs("loss_wait", 5'b01110);

    // One-cycle glitch while in STABLE: back to WAIT_LOCK at G+7, STABLE
    // again at G+8, so rst_mem now falls at G+16 instead of G+10
    locked = 1'b1;
    step(5); locked = 1'b0;
    step(1); locked = 1'b1;
    step(10); check_outs("glitch_pre_mem", 5'b01110);
    step(1);  check_outs("glitch_mem", 5'b00110);
    step(4);  check_outs("glitch_sys", 5'b00010);
    step(4);  check_outs("glitch_run", 5'b00001);

    // soft_rst coincident with lock loss at the FSM: lock loss wins
    locked = 1'b0;
    step(2); check_outs("coinc_pre", 5'b00001);
    soft_rst = 1'b1;
    step(1); soft_rst = 1'b0;
    check_outs("coinc_pll", 5'b11110);
    check_val("coinc_retry", 32'(retry_count), 32'd0);

    // No lock: PLL_RESET entered at T0; retries every 103 cycles, saturating
    step(102);
    check_outs("to_wait_end", 5'b01110);
    check_val("to_retry0", 32'(retry_count), 32'd0);
    step(1);
    check_outs("to_pll1", 5'b11110);
    check_val("to_retry1", 32'(retry_count), 32'd1);
    for (int k = 2; k <= 17; k++) begin
      step(103);
      check_outs($sformatf("to_pll%0d", k), 5'b11110);
      check_val($sformatf("to_retry%0d", k), 32'(retry_count),
                (k > 15) ? 32'd15 : 32'(k));
    end

    // rst mid-sequence takes effect on the next edge and clears retry_count
    rst = 1'b1;
    step(1);
    check_outs("rst_mid_outs", 5'b11110);
    check_val("rst_mid_retry", 32'(retry_count), 32'd0);

    // Restart with lock already present: STABLE at R4, REL_MEM at R12
    locked = 1'b1;
    step(1); rst = 1'b0;
    step(3); check_outs("r2_wait", 5'b01110);
    step(8); check_outs("r2_pre_mem", 5'b01110);
    step(1); check_outs("r2_mem", 5'b00110);

    // soft_rst in REL_MEM
    soft_rst = 1'b1;
    step(1); soft_rst = 1'b0;
    check_outs("r2_soft", 5'b01110);
    step(7); check_outs("r2_soft_pre_mem", 5'b01110);
    step(1); check_outs("r2_soft_mem", 5'b00110);
    step(4); check_outs("r2_sys", 5'b00010);

    // Lock loss in REL_SYS
    locked = 1'b0;
    step(2); check_outs("r2_loss_sync", 5'b00010);
    step(1); check_outs("r2_loss_pll", 5'b11110);
    check_val("r2_loss_retry", 32'(retry_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
